// File: rtl/viola_pkg.sv
// Shared core definitions: op codes, tag width and the reservation
// station entry layout, used by both the ROB and the reservation station.
package viola_pkg;

    localparam int TAG_W = 3;
    localparam int OP_W  = 5;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [OP_W-1:0]  op_t;

    localparam op_t OP_ADD   = 5'b00000;
    localparam op_t OP_SUB   = 5'b00001;
    localparam op_t OP_AND   = 5'b00010;
    localparam op_t OP_OR    = 5'b00011;
    localparam op_t OP_XOR   = 5'b00100;
    localparam op_t OP_SLL   = 5'b00101;
    localparam op_t OP_SRL   = 5'b00110;
    localparam op_t OP_SRA   = 5'b00111;
    localparam op_t OP_SLT   = 5'b01000;
    localparam op_t OP_SLTU  = 5'b01001;
    localparam op_t OP_ADDI  = 5'b01010;
    localparam op_t OP_BEQ   = 5'b01011;
    localparam op_t OP_BNE   = 5'b01100;
    localparam op_t OP_JAL   = 5'b01101;
    localparam op_t OP_LUI   = 5'b01110;
    localparam op_t OP_AUIPC = 5'b01111;
    localparam op_t OP_LB    = 5'b10010;
    localparam op_t OP_LH    = 5'b10011;
    localparam op_t OP_LW    = 5'b10100;
    localparam op_t OP_LBU   = 5'b10101;
    localparam op_t OP_LHU   = 5'b10110;
    localparam op_t OP_SB    = 5'b10111;
    localparam op_t OP_SH    = 5'b11000;
    localparam op_t OP_SW    = 5'b11001;
    localparam op_t NOP_OP   = 5'b11111;

    typedef struct packed {
        logic        busy;
        op_t         op;
        tag_t        dest;
        tag_t        q1;
        tag_t        q2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
    } rs_entry_t;

    // Loads and stores go to the memory unit, never to this station.
    function automatic logic is_mem_op(op_t op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

endpackage

// File: rtl/rs_select.sv
// Priority encoder over the station: lowest free slot for dispatch,
// lowest ready slot for issue.
module rs_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] ready,
    output logic             free_found,
    output logic [IDX_W-1:0] free_idx,
    output logic             ready_found,
    output logic [IDX_W-1:0] ready_idx
);

    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        // Scan downwards so the lowest index is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready[i]) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched ops until both operands
// are captured from the CDB, then issues the lowest-index ready entry.
module reservation_station #(
    parameter int         RS_DEPTH = 4,
    parameter logic [4:0] NOP_OP   = viola_pkg::NOP_OP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  op_in,
    input  logic [31:0] value1_in,
    input  logic [31:0] value2_in,
    input  logic [2:0]  query1_in,
    input  logic [2:0]  query2_in,
    input  logic [31:0] imm_in,
    input  logic [2:0]  target_in,
    input  logic [2:0]  alu_num,
    input  logic [31:0] alu_value,
    input  logic [2:0]  mem_num,
    input  logic [31:0] mem_value,
    input  logic        flush,
    output logic        rs_full,
    output logic        issue_valid,
    output logic [4:0]  issue_op,
    output logic [31:0] issue_a,
    output logic [31:0] issue_b,
    output logic [31:0] issue_imm,
    output logic [2:0]  issue_num
);

    import viola_pkg::*;

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    rs_entry_t ent_q [RS_DEPTH];
    rs_entry_t ent_d [RS_DEPTH];

    logic [RS_DEPTH-1:0] busy_vec;
    logic [RS_DEPTH-1:0] ready_vec;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic                issue_found;
    logic [IDX_W-1:0]    issue_idx;
    logic                dispatch_ok;
    logic                full_d;
    int                  occ;

    // mem_value wins when both CDB ports carry the same tag.
    function automatic logic [31:0] fwd_val(tag_t q, logic [31:0] v);
        if (q != '0 && q == mem_num) return mem_value;
        if (q != '0 && q == alu_num) return alu_value;
        return v;
    endfunction

    function automatic tag_t fwd_tag(tag_t q);
        if (q != '0 && (q == mem_num || q == alu_num)) return '0;
        return q;
    endfunction

    assign dispatch_ok = (op_in != NOP_OP)
                      && (target_in != '0)
                      && !is_mem_op(op_in);

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy
                        && (ent_q[i].q1 == '0)
                        && (ent_q[i].q2 == '0);
        end
    end

    rs_select #(
        .DEPTH (RS_DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .busy        (busy_vec),
        .ready       (ready_vec),
        .free_found  (free_found),
        .free_idx    (free_idx),
        .ready_found (issue_found),
        .ready_idx   (issue_idx)
    );

    always_comb begin
        ent_d = ent_q;
        occ   = 0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent_q[i].busy) begin
                ent_d[i].v1 = fwd_val(ent_q[i].q1, ent_q[i].v1);
                ent_d[i].q1 = fwd_tag(ent_q[i].q1);
                ent_d[i].v2 = fwd_val(ent_q[i].q2, ent_q[i].v2);
                ent_d[i].q2 = fwd_tag(ent_q[i].q2);
            end
            if (issue_found && issue_idx == IDX_W'(i))
                ent_d[i].busy = 1'b0;
        end
        // The slot chosen here was free before the edge, so it never
        // collides with the entry being issued.
        if (dispatch_ok && free_found) begin
            ent_d[free_idx] = '{
                busy: 1'b1,
                op:   op_in,
                dest: target_in,
                q1:   fwd_tag(query1_in),
                q2:   fwd_tag(query2_in),
                v1:   fwd_val(query1_in, value1_in),
                v2:   fwd_val(query2_in, value2_in),
                imm:  imm_in
            };
        end
        for (int i = 0; i < RS_DEPTH; i++)
            occ = occ + (ent_d[i].busy ? 1 : 0);
        full_d = (occ >= RS_DEPTH - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++)
                ent_q[i] <= '0;
            rs_full     <= 1'b0;
            issue_valid <= 1'b0;
            issue_op    <= NOP_OP;
            issue_a     <= '0;
            issue_b     <= '0;
            issue_imm   <= '0;
            issue_num   <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++)
                ent_q[i] <= '0;
            rs_full     <= 1'b0;
            issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++)
                ent_q[i] <= ent_d[i];
            rs_full     <= full_d;
            issue_valid <= issue_found;
            if (issue_found) begin
                issue_op  <= ent_q[issue_idx].op;
                issue_a   <= ent_q[issue_idx].v1;
                issue_b   <= ent_q[issue_idx].v2;
                issue_imm <= ent_q[issue_idx].imm;
                issue_num <= ent_q[issue_idx].dest;
            end
        end
    end

    // The ROB is expected to honour rs_full; a drop here loses an op.
    always_ff @(posedge clk) begin
        if (!rst && !flush && dispatch_ok)
            assert (free_found)
            else $warning("reservation_station: dispatch tag %0d dropped, station busy",
                          target_in);
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: a cycle-by-cycle vector table
// plus hand sequences for full/drop, flush and reset.
module tb_reservation_station;

    import viola_pkg::*;

    typedef struct packed {
        logic        v;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [2:0]  num;
        logic        full;
    } out_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [2:0]  q1;
        logic [2:0]  q2;
        logic [31:0] imm;
        logic [2:0]  tgt;
        logic [2:0]  an;
        logic [31:0] av;
        logic [2:0]  mn;
        logic [31:0] mv;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  op_in;
    logic [31:0] value1_in, value2_in, imm_in;
    logic [2:0]  query1_in, query2_in, target_in;
    logic [2:0]  alu_num, mem_num;
    logic [31:0] alu_value, mem_value;
    logic        flush;
    logic        rs_full, issue_valid;
    logic [4:0]  issue_op;
    logic [31:0] issue_a, issue_b, issue_imm;
    logic [2:0]  issue_num;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    reservation_station dut (
        .clk         (clk),
        .rst         (rst),
        .op_in       (op_in),
        .value1_in   (value1_in),
        .value2_in   (value2_in),
        .query1_in   (query1_in),
        .query2_in   (query2_in),
        .imm_in      (imm_in),
        .target_in   (target_in),
        .alu_num     (alu_num),
        .alu_value   (alu_value),
        .mem_num     (mem_num),
        .mem_value   (mem_value),
        .flush       (flush),
        .rs_full     (rs_full),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_imm   (issue_imm),
        .issue_num   (issue_num)
    );

    function automatic out_t o(logic v, logic [4:0] op, logic [31:0] a,
                               logic [31:0] b, logic [31:0] imm,
                               logic [2:0] num, logic full);
        return '{v: v, op: op, a: a, b: b, imm: imm, num: num, full: full};
    endfunction

    function automatic vec_t mk(logic [4:0] op, logic [31:0] v1,
                                logic [31:0] v2, logic [2:0] q1,
                                logic [2:0] q2, logic [31:0] imm,
                                logic [2:0] tgt, logic [2:0] an,
                                logic [31:0] av, logic [2:0] mn,
                                logic [31:0] mv, out_t exp);
        return '{op: op, v1: v1, v2: v2, q1: q1, q2: q2, imm: imm,
                 tgt: tgt, an: an, av: av, mn: mn, mv: mv, exp: exp};
    endfunction

    function automatic out_t dut_out();
        return o(issue_valid, issue_op, issue_a, issue_b, issue_imm,
                 issue_num, rs_full);
    endfunction

    task automatic drive(logic [4:0] op, logic [31:0] v1, logic [31:0] v2,
                         logic [2:0] q1, logic [2:0] q2, logic [31:0] imm,
                         logic [2:0] tgt, logic [2:0] an, logic [31:0] av,
                         logic [2:0] mn, logic [31:0] mv);
        op_in = op; value1_in = v1; value2_in = v2;
        query1_in = q1; query2_in = q2; imm_in = imm;
        target_in = tgt; alu_num = an; alu_value = av;
        mem_num = mn; mem_value = mv;
    endtask

    task automatic idle();
        drive(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_out(string name, out_t exp);
        out_t got;
        got = dut_out();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got v=%b op=%h a=%h b=%h imm=%h num=%0d full=%b expected v=%b op=%h a=%h b=%h imm=%h num=%0d full=%b",
                     name, got.v, got.op, got.a, got.b, got.imm, got.num,
                     got.full, exp.v, exp.op, exp.a, exp.b, exp.imm,
                     exp.num, exp.full);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        idle();

        // Hold-value bookkeeping: idle rows expect the last issued fields.
        tbl.push_back(mk(OP_ADD, 5, 7, 0, 0, 'h11, 3, 0, 0, 0, 0,
                         o(0, NOP_OP, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(1, OP_ADD, 5, 7, 'h11, 3, 0)));
        tbl.push_back(mk(OP_SUB, 0, 3, 4, 0, 0, 2, 0, 0, 0, 0,
                         o(0, OP_ADD, 5, 7, 'h11, 3, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(0, OP_ADD, 5, 7, 'h11, 3, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 4, 9, 0, 0,
                         o(0, OP_ADD, 5, 7, 'h11, 3, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(1, OP_SUB, 9, 3, 0, 2, 0)));
        tbl.push_back(mk(OP_XOR, 'h20, 0, 0, 5, 'h44, 5, 0, 0, 5, 'h10,
                         o(0, OP_SUB, 9, 3, 0, 2, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(1, OP_XOR, 'h20, 'h10, 'h44, 5, 0)));
        tbl.push_back(mk(OP_AND, 0, 1, 6, 0, 0, 1, 0, 0, 0, 0,
                         o(0, OP_XOR, 'h20, 'h10, 'h44, 5, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 6, 'hAA, 6, 'hBB,
                         o(0, OP_XOR, 'h20, 'h10, 'h44, 5, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(1, OP_AND, 'hBB, 1, 0, 1, 0)));
        tbl.push_back(mk(OP_OR, 0, 2, 7, 0, 0, 6, 0, 0, 0, 0,
                         o(0, OP_AND, 'hBB, 1, 0, 1, 0)));
        tbl.push_back(mk(OP_SLT, 0, 4, 7, 0, 0, 7, 0, 0, 0, 0,
                         o(0, OP_AND, 'hBB, 1, 0, 1, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 7, 'h55, 0, 0,
                         o(0, OP_AND, 'hBB, 1, 0, 1, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(1, OP_OR, 'h55, 2, 0, 6, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(1, OP_SLT, 'h55, 4, 0, 7, 0)));
        tbl.push_back(mk(OP_LW, 1, 1, 0, 0, 0, 4, 0, 0, 0, 0,
                         o(0, OP_SLT, 'h55, 4, 0, 7, 0)));
        tbl.push_back(mk(OP_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(0, OP_SLT, 'h55, 4, 0, 7, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(0, OP_SLT, 'h55, 4, 0, 7, 0)));
        tbl.push_back(mk(OP_ADD, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0,
                         o(0, OP_SLT, 'h55, 4, 0, 7, 0)));
        tbl.push_back(mk(OP_SUB, 8, 2, 0, 0, 0, 2, 0, 0, 0, 0,
                         o(1, OP_ADD, 1, 1, 0, 1, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(1, OP_SUB, 8, 2, 0, 2, 0)));
        tbl.push_back(mk(5'b10001, 3, 4, 0, 0, 0, 3, 0, 0, 0, 0,
                         o(0, OP_SUB, 8, 2, 0, 2, 0)));
        tbl.push_back(mk(5'b11010, 6, 7, 0, 0, 0, 4, 0, 0, 0, 0,
                         o(1, 5'b10001, 3, 4, 0, 3, 0)));
        tbl.push_back(mk(OP_SW, 1, 1, 0, 0, 0, 5, 0, 0, 0, 0,
                         o(1, 5'b11010, 6, 7, 0, 4, 0)));
        tbl.push_back(mk(OP_LB, 1, 1, 0, 0, 0, 6, 0, 0, 0, 0,
                         o(0, 5'b11010, 6, 7, 0, 4, 0)));
        tbl.push_back(mk(NOP_OP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         o(0, 5'b11010, 6, 7, 0, 4, 0)));

        step();
        step();
        chk_out("reset_state", o(0, NOP_OP, 0, 0, 0, 0, 0));
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].v1, tbl[i].v2, tbl[i].q1, tbl[i].q2,
                  tbl[i].imm, tbl[i].tgt, tbl[i].an, tbl[i].av,
                  tbl[i].mn, tbl[i].mv);
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Fill the station, then one dispatch too many.
        for (int i = 1; i <= 4; i++) begin
            drive(OP_ADD, 0, i, 6, 0, 0, 3'(i), 0, 0, 0, 0);
            step();
            chk($sformatf("fill%0d_full", i), 32'(rs_full), 32'(i >= 3));
            chk($sformatf("fill%0d_valid", i), 32'(issue_valid), 0);
        end
        drive(OP_ADD, 0, 5, 6, 0, 0, 5, 0, 0, 0, 0);
        step();
        chk("drop_full", 32'(rs_full), 1);
        drive(NOP_OP, 0, 0, 0, 0, 0, 0, 6, 'h66, 0, 0);
        step();
        chk("wake_all_valid", 32'(issue_valid), 0);
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("drain%0d_valid", i), 32'(issue_valid), 1);
            chk($sformatf("drain%0d_num", i), 32'(issue_num), i);
            chk($sformatf("drain%0d_a", i), issue_a, 'h66);
            chk($sformatf("drain%0d_b", i), issue_b, i);
            chk($sformatf("drain%0d_full", i), 32'(rs_full), 32'(i == 1));
        end
        step();
        chk("dropped_absent", 32'(issue_valid), 0);

        // Flush with a ready entry pending and a dispatch on the same edge.
        drive(OP_ADD, 0, 1, 6, 0, 0, 1, 0, 0, 0, 0);
        step();
        drive(OP_ADD, 0, 2, 6, 0, 0, 2, 0, 0, 0, 0);
        step();
        drive(OP_ADD, 'h77, 1, 0, 0, 0, 3, 0, 0, 0, 0);
        step();
        chk("pre_flush_full", 32'(rs_full), 1);
        drive(OP_SUB, 9, 9, 0, 0, 0, 4, 0, 0, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(issue_valid), 0);
        chk("flush_full", 32'(rs_full), 0);
        drive(NOP_OP, 0, 0, 0, 0, 0, 0, 6, 'h1, 0, 0);
        step();
        chk("post_flush_valid1", 32'(issue_valid), 0);
        idle();
        step();
        chk("post_flush_valid2", 32'(issue_valid), 0);
        drive(OP_ADD, 'h12, 'h34, 0, 0, 0, 7, 0, 0, 0, 0);
        step();
        idle();
        step();
        chk("post_flush_reuse_num", 32'(issue_num), 7);
        chk("post_flush_reuse_a", issue_a, 'h12);

        // Reset in the middle of traffic.
        drive(OP_ADD, 'hA1, 'hB2, 0, 0, 'hC3, 5, 0, 0, 0, 0);
        step();
        drive(OP_ADD, 0, 0, 6, 0, 0, 6, 0, 0, 0, 0);
        step();
        chk("pre_rst_num", 32'(issue_num), 5);
        drive(OP_ADD, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        chk_out("mid_reset", o(0, NOP_OP, 0, 0, 0, 0, 0));
        rst = 1'b0;
        drive(OP_OR, 3, 0, 0, 0, 0, 2, 6, 'h5, 0, 0);
        step();
        chk("post_rst_valid", 32'(issue_valid), 0);
        idle();
        step();
        chk_out("post_rst_issue", o(1, OP_OR, 3, 0, 0, 2, 0));
        step();
        chk("post_rst_discarded", 32'(issue_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
